// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   DEFAULT_RESET_VEC / DEFAULT_TRAP_VEC : default vectors for pc_gen
//   pc_src_e                             : next-PC source, exported for trace/debug
package cpu_pkg;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0180;

  typedef enum logic [2:0] {
    PC_SRC_SEQ,
    PC_SRC_BRANCH,
    PC_SRC_JUMP,
    PC_SRC_RET,
    PC_SRC_ERET,
    PC_SRC_TRAP,
    PC_SRC_HOLD
  } pc_src_e;

endpackage

// File: rtl/pc_gen_if.sv
// Control/status bundle between decode (master) and pc_gen (slave).
//   master drives: stall, branch, offset, jump, call, ret, target, trap, eret
//   slave drives : ins_addr, epc, ras_empty, ras_full, ras_underflow, pc_src
interface pc_gen_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              branch;
  logic [ADDR_W-1:0] offset;
  logic              jump;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic              trap;
  logic              eret;

  logic [ADDR_W-1:0] ins_addr;
  logic [ADDR_W-1:0] epc;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_underflow;
  pc_src_e           pc_src;

  modport master (
    output stall, branch, offset, jump, call, ret, target, trap, eret,
    input  ins_addr, epc, ras_empty, ras_full, ras_underflow, pc_src
  );

  modport slave (
    input  stall, branch, offset, jump, call, ret, target, trap, eret,
    output ins_addr, epc, ras_empty, ras_full, ras_underflow, pc_src
  );
endinterface

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack.
//   clk, reset (async, active-low)
//   push, pop : push+pop on a non-empty stack replaces the top entry;
//               pop on empty is ignored; push on full overwrites the oldest
//   wdata     : value pushed
//   top       : current top entry (undefined when empty)
//   empty/full: count == 0 / count == DEPTH
module ras_stack #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  tp;
  logic [PTR_W:0]    cnt;

  logic              do_pop;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;

  assign empty  = (cnt == '0);
  assign full   = (cnt == (PTR_W+1)'(DEPTH));
  assign top    = mem[tp];
  assign do_pop = pop & ~empty;

  // Replace writes the current top slot; a plain push writes one slot up,
  // which on a full stack is the oldest entry, so the wrap drops it.
  always_comb begin
    wr_en  = push;
    wr_idx = do_pop ? tp : tp + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tp  <= '0;
      cnt <= '0;
    end else if (push && !do_pop) begin
      tp <= tp + 1'b1;
      if (!full) cnt <= cnt + 1'b1;
    end else if (do_pop && !push) begin
      tp  <= tp - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with stall, trap/eret and a return-address stack.
//   clk, reset (async, active-low)
//   bus (pc_gen_if.slave): control strobes in; ins_addr, epc, RAS status out
// Next-PC priority: trap > stall > eret > ret > jump/call > branch > sequential.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int unsigned             ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]       RESET_VEC   = ADDR_W'(DEFAULT_RESET_VEC),
  parameter logic [ADDR_W-1:0]       TRAP_VEC    = ADDR_W'(DEFAULT_TRAP_VEC),
  parameter int unsigned             INSTR_BYTES = 4,
  parameter int unsigned             RAS_DEPTH   = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.slave  bus
);
  localparam logic [ADDR_W-1:0] INC        = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] nxt_raw;
  logic [ADDR_W-1:0] nxt_pc;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              accept;
  logic              ras_push;
  logic              ras_pop;
  pc_src_e           src;

  assign ret_addr = pc + INC;

  always_comb begin
    src      = PC_SRC_SEQ;
    nxt_raw  = ret_addr;
    accept   = ~bus.trap & ~bus.stall & ~bus.eret;
    ras_push = accept & bus.call;
    ras_pop  = accept & bus.ret;

    if (bus.trap) begin
      src     = PC_SRC_TRAP;
      nxt_raw = TRAP_VEC;
    end else if (bus.stall) begin
      src     = PC_SRC_HOLD;
      nxt_raw = pc;
    end else if (bus.eret) begin
      src     = PC_SRC_ERET;
      nxt_raw = epc;
    end else if (bus.ret) begin
      src     = PC_SRC_RET;
      nxt_raw = ras_empty ? bus.target : ras_top;
    end else if (bus.jump || bus.call) begin
      src     = PC_SRC_JUMP;
      nxt_raw = bus.target;
    end else if (bus.branch) begin
      src     = PC_SRC_BRANCH;
      nxt_raw = pc + bus.offset;
    end

    nxt_pc = nxt_raw & ~ALIGN_MASK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= RESET_VEC;
      epc <= '0;
    end else begin
      pc <= nxt_pc;
      if (bus.trap) epc <= pc;
    end
  end

  ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .wdata (ret_addr),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign bus.ins_addr      = pc;
  assign bus.epc           = epc;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_underflow = ras_pop & ras_empty;
  assign bus.pc_src        = src;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(32)) bus ();

  pc_gen #(
    .ADDR_W      (32),
    .RESET_VEC   (32'h0),
    .TRAP_VEC    (32'h180),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  // Reference model: stack held as a queue, newest at the back.
  logic [31:0] m_pc, m_epc, m_t;
  logic [31:0] m_ras [$];

  task automatic m_push(input logic [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc  = 32'h0;
      m_epc = 32'h0;
      m_ras.delete();
    end else if (bus.trap) begin
      m_epc = m_pc;
      m_pc  = 32'h180;
    end else if (bus.stall) begin
      m_pc = m_pc;
    end else if (bus.eret) begin
      m_pc = m_epc & ~32'h3;
    end else begin
      if (bus.ret) begin
        if (m_ras.size() > 0) m_t = m_ras.pop_back();
        else                  m_t = bus.target;
        if (bus.call) m_push(m_pc + 32'd4);
        m_pc = m_t & ~32'h3;
      end else if (bus.call || bus.jump) begin
        if (bus.call) m_push(m_pc + 32'd4);
        m_pc = bus.target & ~32'h3;
      end else if (bus.branch) begin
        m_pc = (m_pc + bus.offset) & ~32'h3;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  function automatic logic m_underflow();
    return rst_n && !bus.trap && !bus.stall && !bus.eret && bus.ret && (m_ras.size() == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Compare process: inputs are stable mid-cycle, state reflects the last edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ins_addr",  bus.ins_addr, m_pc);
      chk("epc",       bus.epc, m_epc);
      chk("ras_empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
      chk("ras_full",  32'(bus.ras_full), 32'(m_ras.size() == DEPTH));
      chk("ras_underflow", 32'(bus.ras_underflow), 32'(m_underflow()));
    end
  end

  task automatic clr();
    bus.stall = 0; bus.branch = 0; bus.offset = '0; bus.jump = 0; bus.call = 0;
    bus.ret = 0; bus.target = '0; bus.trap = 0; bus.eret = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic do_jump(input logic [31:0] t);
    bus.jump = 1; bus.target = t; cyc();
  endtask

  task automatic do_call(input logic [31:0] t);
    bus.call = 1; bus.target = t; cyc();
  endtask

  task automatic do_ret(input logic [31:0] t);
    bus.ret = 1; bus.target = t; cyc();
  endtask

  initial begin
    clr();
    #1;
    chk("reset_pc",    bus.ins_addr, 32'h0);
    chk("reset_epc",   bus.epc, 32'h0);
    chk("reset_empty", 32'(bus.ras_empty), 32'd1);
    chk("reset_full",  32'(bus.ras_full), 32'd0);
    chk("reset_und",   32'(bus.ras_underflow), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("idle0", bus.ins_addr, 32'h0);
    cyc(); chk("idle1", bus.ins_addr, 32'h4);
    cyc(); chk("idle2", bus.ins_addr, 32'h8);
    cyc(); chk("idle3", bus.ins_addr, 32'hC);
    chk("idle_empty", 32'(bus.ras_empty), 32'd1);
    cyc(); chk("seq_10", bus.ins_addr, 32'h10);

    bus.branch = 1; bus.offset = -32'sd8; cyc();
    chk("branch_back", bus.ins_addr, 32'h08);
    do_jump(32'h103); chk("jump_align", bus.ins_addr, 32'h100);

    do_jump(32'h20);
    do_call(32'h200); chk("call1", bus.ins_addr, 32'h200);
    do_call(32'h300); chk("call2", bus.ins_addr, 32'h300);
    do_ret(32'h0);    chk("ret1", bus.ins_addr, 32'h204);
    do_ret(32'h0);    chk("ret2", bus.ins_addr, 32'h24);
    bus.ret = 1; bus.target = 32'h40; #1;
    chk("underflow_flag", 32'(bus.ras_underflow), 32'd1);
    cyc(); chk("ret_empty", bus.ins_addr, 32'h40);

    do_jump(32'h0);
    do_call(32'h10); do_call(32'h20); do_call(32'h30);
    chk("not_full3", 32'(bus.ras_full), 32'd0);
    do_call(32'h40); chk("full4", 32'(bus.ras_full), 32'd1);
    do_call(32'h50); chk("full5", 32'(bus.ras_full), 32'd1);
    do_ret(32'h0); chk("ovf_ret1", bus.ins_addr, 32'h44);
    do_ret(32'h0); chk("ovf_ret2", bus.ins_addr, 32'h34);
    do_ret(32'h0); chk("ovf_ret3", bus.ins_addr, 32'h24);
    do_ret(32'h0); chk("ovf_ret4", bus.ins_addr, 32'h14);
    chk("ovf_empty", 32'(bus.ras_empty), 32'd1);

    bus.stall = 1; bus.jump = 1; bus.target = 32'h999; cyc();
    bus.stall = 1; bus.jump = 1; bus.target = 32'h999; cyc();
    chk("stall_hold", bus.ins_addr, 32'h14);
    do_jump(32'h50);
    bus.stall = 1; bus.trap = 1; cyc();
    chk("trap_pc", bus.ins_addr, 32'h180);
    chk("trap_epc", bus.epc, 32'h50);
    bus.eret = 1; cyc();
    chk("eret_pc", bus.ins_addr, 32'h50);

    do_call(32'h60); do_call(32'h70);
    chk("two_deep", 32'(bus.ras_empty), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc",    bus.ins_addr, 32'h0);
    chk("async_empty", 32'(bus.ras_empty), 32'd1);
    chk("async_epc",   bus.epc, 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      bus.trap   = ($urandom_range(31) == 0);
      bus.stall  = ($urandom_range(7) == 0);
      bus.eret   = ($urandom_range(15) == 0);
      bus.ret    = ($urandom_range(5) == 0);
      bus.call   = ($urandom_range(4) == 0);
      bus.jump   = ($urandom_range(7) == 0);
      bus.branch = ($urandom_range(3) == 0);
      bus.offset = $urandom();
      bus.target = $urandom();
      if (i == 300) begin
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      cyc();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the single-cycle CPU, the successor of the current fixed 32-bit PC. Adds stall, a trap/return path with an exception PC register, and a small circular return-address stack (RAS) for call/return. Sits at the front of the datapath: drives the instruction-memory address; decode supplies the control strobes for the same cycle.

## Interface
- `ADDR_W`, 32, PC/address width (≥ 8).
- `RESET_VEC`, 0, PC value on reset.
- `TRAP_VEC`, 32'h0000_0180, PC loaded on trap (truncated to `ADDR_W`).
- `INSTR_BYTES`, 4, sequential increment; power of two.
- `RAS_DEPTH`, 4, return-address stack entries; power of two, ≥ 2.

- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `stall` in 1: hold PC, ignore all redirects except `trap`.
- `branch` in 1: take `offset`.
- `offset` in `ADDR_W`: signed byte offset, relative to current PC.
- `jump` in 1: absolute redirect to `target`.
- `call` in 1: jump to `target` and push return address.
- `ret` in 1: pop RAS and go to popped address.
- `target` in `ADDR_W`: absolute target for `jump`/`call`; fallback for `ret` on empty RAS.
- `trap` in 1: go to `TRAP_VEC`, save PC into EPC.
- `eret` in 1: go to EPC.
- `ins_addr` out `ADDR_W`: current PC.
- `epc` out `ADDR_W`: exception PC register.
- `ras_empty` out 1, `ras_full` out 1: RAS status.
- `ras_underflow` out 1: combinational, `ret` accepted while RAS empty.

## Operation
- Next-PC priority, highest first: `trap` → `TRAP_VEC`; `stall` → hold; `eret` → `epc`; `ret` → RAS top (or `target` if empty); `jump` or `call` → `target`; `branch` → `pc + offset`; else `pc + INSTR_BYTES`.
- All arithmetic modulo 2^`ADDR_W`; wrap-around is silent.
- Low log2(`INSTR_BYTES`) bits of every next-PC value are forced to 0.
- `trap`: `epc <= pc` (the trapping instruction), overrides `stall`; RAS untouched.
- `call` (not stalled, no higher-priority event): push `pc + INSTR_BYTES`. When full, push overwrites the oldest entry; count stays at `RAS_DEPTH`.
- `ret` (not stalled, no higher-priority event): pop if non-empty; if empty, count stays 0, PC = `target`, `ras_underflow` = 1.
- `call` and `ret` together: `ret` wins for PC; top entry is replaced by `pc + INSTR_BYTES` (pop+push, count unchanged; if empty, push only).
- Stalled or trapped cycle: RAS pointer/count unchanged.
- RAS: circular buffer, top pointer and count 0..`RAS_DEPTH`; `ras_empty` = count==0, `ras_full` = count==`RAS_DEPTH`.

## Timing
- Reset (`reset` low, asynchronous): `ins_addr` = `RESET_VEC`, `epc` = 0, RAS count = 0 (`ras_empty`=1, `ras_full`=0, `ras_underflow`=0). Entry contents need not be cleared.
- Release is sampled on the first rising `clk` with `reset` high; first update that edge.
- `ins_addr`, `epc`, `ras_*` are registered; next-PC select is combinational from inputs and current state; one-cycle latency from strobe to new `ins_addr`.
- Reset asserted mid-operation: immediate return to reset values regardless of clock.

## Structure
- Shared package `cpu_pkg`: default `RESET_VEC`/`TRAP_VEC` constants and a next-PC source enum (SEQ, BRANCH, JUMP, RET, ERET, TRAP, HOLD) for debug/trace.
- One sub-module: `ras_stack` (circular buffer, push/pop/replace, count, full/empty), instantiated once.

## Test plan
- Reset then 3 idle cycles, defaults → `ins_addr` 0, 4, 8, 12; `ras_empty`=1.
- At PC 0x10: `branch`, `offset`=-8 → 0x08; next `jump` `target`=0x103 → 0x100 (low bits cleared).
- `call` at 0x20→0x200, `call` at 0x200→0x300, `ret` → 0x204, `ret` → 0x24, `ret` with `target`=0x40 → 0x40, `ras_underflow`=1.
- `RAS_DEPTH`=4: 5 calls from 0x0,0x10,0x20,0x30,0x40 then 4 rets → 0x44,0x34,0x24,0x14; `ras_full` after 4th call, `ras_empty` after 4th ret.
- `stall` with `jump` held 2 cycles → PC unchanged; `trap` during `stall` at PC 0x50 → 0x180, `epc`=0x50; `eret` → 0x50.
- Assert `reset` low between clock edges with RAS count 2 → `ins_addr`=`RESET_VEC`, `ras_empty`=1 immediately.
